count_bcd_converter: RTL and testbench

COUNT_BCD_CONVERTER -- requirements
Module: count_bcd_converter

---
 rtl/bottling_pkg.sv | 17 +
 rtl/bcd_dabble_step.sv | 22 ++
 rtl/count_bcd_converter.sv | 88 ++++++++
 tb/tb_count_bcd_converter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bottling_pkg.sv
// Shared widths, digit type and FSM encoding for the binary-to-BCD converter.
package bottling_pkg;

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORK_W = DIGITS * NIB_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W);

  typedef logic [NIB_W-1:0] bcd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift one bit in.
module bcd_dabble_step
  import bottling_pkg::*;
(
  input  logic [WORK_W-1:0] i_work,
  input  logic              i_bit,
  output logic [WORK_W-1:0] o_work_c
);

  logic [WORK_W-1:0] w_adj;

  always_comb begin
    w_adj = i_work;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (i_work[d*NIB_W +: NIB_W] >= NIB_W'(5))
        w_adj[d*NIB_W +: NIB_W] = i_work[d*NIB_W +: NIB_W] + NIB_W'(3);
    end
    // The top bit shifted out is always 0 for an 8-bit input (max hundreds = 2).
    o_work_c = {w_adj[WORK_W-2:0], i_bit};
  end

endmodule

// File: rtl/count_bcd_converter.sv
// Serial 8-bit binary to 3-digit BCD converter, one bit per cycle, 8-cycle latency.
// Define COUNT_BCD_BLANK_EN to replace leading-zero digits with BLANK_CODE.
module count_bcd_converter
  import bottling_pkg::*;
#(
  parameter bcd_t BLANK_CODE = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output bcd_t             bcd [DIGITS:1]
);

`ifdef COUNT_BCD_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIN_W-1:0]  r_bin;
  logic [WORK_W-1:0] r_work;
  logic [WORK_W-1:0] w_work_next;
  bcd_t              w_hund;
  bcd_t              w_tens;
  bcd_t              w_ones;
  logic              w_blank_h;
  logic              w_blank_t;

  bcd_dabble_step u_step (
    .i_work   (r_work),
    .i_bit    (r_bin[BIN_W-1]),
    .o_work_c (w_work_next)
  );

  assign w_hund    = w_work_next[2*NIB_W +: NIB_W];
  assign w_tens    = w_work_next[NIB_W +: NIB_W];
  assign w_ones    = w_work_next[0 +: NIB_W];
  assign w_blank_h = BLANK_EN && (w_hund == NIB_W'(0));
  assign w_blank_t = w_blank_h && (w_tens == NIB_W'(0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_work  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd[3]  <= '0;
      bcd[2]  <= '0;
      bcd[1]  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_work  <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_work <= w_work_next;
          r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt  <= r_cnt + CNT_W'(1);
          // Last bit: publish the final digits straight from the step output.
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd[3]  <= w_blank_h ? BLANK_CODE : w_hund;
            bcd[2]  <= w_blank_t ? BLANK_CODE : w_tens;
            bcd[1]  <= w_ones;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_bcd_converter.sv
// Self-checking bench for count_bcd_converter; honours COUNT_BCD_BLANK_EN.
module tb_count_bcd_converter;

  typedef struct { int k;   logic [11:0] val; } exp_t;
  typedef struct { int cyc; logic [11:0] val; } obs_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] bcd [3:1];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exq[$];
  obs_t obs[$];

  count_bcd_converter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // Record every done pulse with the edge number it followed.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) obs.push_back('{cyc, {bcd[3], bcd[2], bcd[1]}});
  end

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef COUNT_BCD_BLANK_EN
    if (v < 100) r[11:8] = 4'hF;
    if (v < 10)  r[7:4]  = 4'hF;
`endif
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    #1;
    exq.push_back('{cyc, ref_bcd(int'(b))});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 24; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    bin   = '0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if ({bcd[3], bcd[2], bcd[1]} !== 12'h000) begin
      errors++;
      $display("FAIL reset_bcd: got %h expected 000", {bcd[3], bcd[2], bcd[1]});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    obs_t o;
    exp_t e;
    bit   bad;
    send(8'd173);
    bad = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL basic_busy: busy not high for 8 cycles, got profile error expected busy=1 done=0");
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL basic_edge8: busy=%b done=%b expected 0 1", busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b expected 0", done);
    end
    checks++;
    if (obs.size() == 0 || exq.size() == 0) begin
      errors++;
      $display("FAIL basic_sb: got no result expected one");
    end else begin
      o = obs.pop_front();
      e = exq.pop_front();
      if (o.val !== 12'h173 || o.val !== e.val) begin
        errors++;
        $display("FAIL basic_val: got %h expected 173", o.val);
      end
      checks++;
      if (o.cyc - e.k !== 8) begin
        errors++;
        $display("FAIL basic_lat: got %0d expected 8", o.cyc - e.k);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    int   first_done;
    send(8'd0);
    wait_done();
    first_done = cyc;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done1: done=%b busy=%b expected 1 0", done, busy);
    end
    send(8'd255);
    checks++;
    if (busy !== 1'b1 || exq[exq.size()-1].k !== first_done + 1) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b accept=%0d expected 1 %0d", busy, exq[exq.size()-1].k, first_done + 1);
    end
    wait_done();
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (obs.size() == 0 || exq.size() == 0) begin
        errors++;
        $display("FAIL b2b_sb%0d: got no result expected one", n);
      end else begin
        o = obs.pop_front();
        e = exq.pop_front();
        if (o.val !== e.val) begin
          errors++;
          $display("FAIL b2b_val%0d: got %h expected %h", n, o.val, e.val);
        end
        checks++;
        if (o.cyc - e.k !== 8) begin
          errors++;
          $display("FAIL b2b_lat%0d: got %0d expected 8", n, o.cyc - e.k);
        end
      end
    end
  endtask

  task automatic test_ignore_restart();
    obs_t o;
    exp_t e;
    send(8'd42);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    checks++;
    if (obs.size() == 0 || exq.size() == 0) begin
      errors++;
      $display("FAIL ign_sb: got no result expected one");
    end else begin
      o = obs.pop_front();
      e = exq.pop_front();
      if (o.val !== e.val) begin
        errors++;
        $display("FAIL ign_val: got %h expected %h", o.val, e.val);
      end
      checks++;
      if (o.cyc - e.k !== 8) begin
        errors++;
        $display("FAIL ign_lat: got %0d expected 8", o.cyc - e.k);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_single: extra dones=%0d busy=%b expected 0 0", obs.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    send(8'd99);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    void'(exq.pop_back());
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {bcd[3], bcd[2], bcd[1]} !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_now: busy=%b done=%b bcd=%h expected 0 0 000", busy, done, {bcd[3], bcd[2], bcd[1]});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != 0 || {bcd[3], bcd[2], bcd[1]} !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_quiet: dones=%0d bcd=%h expected 0 000", obs.size(), {bcd[3], bcd[2], bcd[1]});
    end
  endtask

  task automatic test_blank();
    logic [7:0]  vin  [3];
    logic [11:0] want [3];
    obs_t o;
    exp_t e;
    vin[0] = 8'd7; vin[1] = 8'd40; vin[2] = 8'd100;
`ifdef COUNT_BCD_BLANK_EN
    want[0] = 12'hFF7; want[1] = 12'hF40; want[2] = 12'h100;
`else
    want[0] = 12'h007; want[1] = 12'h040; want[2] = 12'h100;
`endif
    for (int i = 0; i < 3; i++) begin
      send(vin[i]);
      wait_done();
      checks++;
      if (obs.size() == 0 || exq.size() == 0) begin
        errors++;
        $display("FAIL blank_sb%0d: got no result expected one", i);
      end else begin
        o = obs.pop_front();
        e = exq.pop_front();
        if (o.val !== want[i]) begin
          errors++;
          $display("FAIL blank_val%0d: got %h expected %h", i, o.val, want[i]);
        end
      end
    end
  endtask

  task automatic test_sweep();
    obs_t o;
    exp_t e;
    for (int v = 0; v < 256; v++) begin
      send(8'(v));
      wait_done();
      checks++;
      if (obs.size() == 0 || exq.size() == 0) begin
        errors++;
        $display("FAIL sweep_sb: bin=%0d got no result expected one", v);
      end else begin
        o = obs.pop_front();
        e = exq.pop_front();
        if (o.val !== e.val) begin
          errors++;
          $display("FAIL sweep_val: bin=%0d got %h expected %h", v, o.val, e.val);
        end
        checks++;
        if (o.cyc - e.k !== 8) begin
          errors++;
          $display("FAIL sweep_lat: bin=%0d got %0d expected 8", v, o.cyc - e.k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_restart();
    test_reset_mid();
    test_sweep();
    test_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
